// File: rtl/procyon_vb_pkg.sv
// Shared victim-buffer types: CCU length codes, entry state and byte extract/merge helpers.
// The helpers work on maximum-width lines and words; callers zero-extend their inputs and truncate the results.
package procyon_vb_pkg;

  localparam int PCYN_VB_MAX_LINE_B = 128;
  localparam int PCYN_VB_MAX_DATA_B = 8;

  typedef logic [PCYN_VB_MAX_LINE_B*8-1:0] pcyn_line_t;
  typedef logic [PCYN_VB_MAX_DATA_B*8-1:0] pcyn_word_t;
  typedef logic [PCYN_VB_MAX_DATA_B-1:0]   pcyn_bsel_t;
  typedef logic [2:0]                      pcyn_ccu_len_t;

  localparam pcyn_ccu_len_t PCYN_CCU_LEN_4B   = 3'd0;
  localparam pcyn_ccu_len_t PCYN_CCU_LEN_8B   = 3'd1;
  localparam pcyn_ccu_len_t PCYN_CCU_LEN_16B  = 3'd2;
  localparam pcyn_ccu_len_t PCYN_CCU_LEN_32B  = 3'd3;
  localparam pcyn_ccu_len_t PCYN_CCU_LEN_64B  = 3'd4;
  localparam pcyn_ccu_len_t PCYN_CCU_LEN_128B = 3'd5;

  typedef enum logic [1:0] {
    PCYN_VB_INVALID = 2'd0,
    PCYN_VB_VALID   = 2'd1,
    PCYN_VB_WB      = 2'd2
  } pcyn_vb_state_t;

  function automatic pcyn_ccu_len_t pcyn_ccu_len(input int line_bytes);
    case (line_bytes)
      8:       return PCYN_CCU_LEN_8B;
      16:      return PCYN_CCU_LEN_16B;
      32:      return PCYN_CCU_LEN_32B;
      64:      return PCYN_CCU_LEN_64B;
      128:     return PCYN_CCU_LEN_128B;
      default: return PCYN_CCU_LEN_4B;
    endcase
  endfunction

  // Selected bytes starting at a byte offset; bytes that fall past the line end read as zero.
  function automatic pcyn_word_t pcyn_vb_extract(input pcyn_line_t line, input int unsigned line_bytes,
                                                 input int unsigned offset, input pcyn_bsel_t sel);
    pcyn_line_t shifted;
    pcyn_word_t result;
    shifted = line >> (offset * 8);
    result  = '0;
    for (int unsigned b = 0; b < PCYN_VB_MAX_DATA_B; b++) begin
      if (sel[b] && ((offset + b) < line_bytes)) result[b*8 +: 8] = shifted[b*8 +: 8];
    end
    return result;
  endfunction

  // Overlay selected bytes at a byte offset; bytes that fall past the line end are dropped.
  function automatic pcyn_line_t pcyn_vb_merge(input pcyn_line_t line, input int unsigned line_bytes,
                                               input int unsigned offset, input pcyn_bsel_t sel,
                                               input pcyn_word_t data);
    pcyn_line_t mask;
    pcyn_line_t wdata;
    mask  = '0;
    wdata = '0;
    for (int unsigned b = 0; b < PCYN_VB_MAX_DATA_B; b++) begin
      if (sel[b] && ((offset + b) < line_bytes)) begin
        mask[b*8 +: 8]  = 8'hFF;
        wdata[b*8 +: 8] = data[b*8 +: 8];
      end
    end
    mask  = mask << (offset * 8);
    wdata = wdata << (offset * 8);
    return (line & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/procyon_vb_entry.sv
// One victim-buffer slot: state, tag and line data, plus tag compares for lookups, store merge and allocate.
// Store merging is compiled in only when PCYN_VB_STORE_MERGE_EN is defined.
module procyon_vb_entry
  import procyon_vb_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH      = 32,
  parameter int OPTN_ADDR_WIDTH      = 32,
  parameter int OPTN_VB_LOOKUP_PORTS = 2,
  parameter int OPTN_DC_LINE_SIZE    = 32,
  localparam int DATA_SIZE = OPTN_DATA_WIDTH / 8,
  localparam int LINE_W    = OPTN_DC_LINE_SIZE * 8,
  localparam int OFF_W     = $clog2(OPTN_DC_LINE_SIZE),
  localparam int TAG_W     = OPTN_ADDR_WIDTH - OFF_W
) (
  input  logic                                        clk,
  input  logic                                        n_rst,
  input  logic                                        i_head,
  input  logic                                        i_grant,
  input  logic                                        i_tail_we,
  input  logic                                        i_victim_valid,
  input  logic [TAG_W-1:0]                            i_victim_tag,
  input  logic [LINE_W-1:0]                           i_victim_data,
  input  logic [OPTN_VB_LOOKUP_PORTS-1:0]             i_lookup_valid,
  input  logic [OPTN_VB_LOOKUP_PORTS-1:0][TAG_W-1:0]  i_lookup_tag,
  input  logic                                        i_store_valid,
  input  logic [TAG_W-1:0]                            i_store_tag,
  input  logic [OFF_W-1:0]                            i_store_offset,
  input  logic [DATA_SIZE-1:0]                        i_store_byte_sel,
  input  logic [OPTN_DATA_WIDTH-1:0]                  i_store_data,
  output pcyn_vb_state_t                              o_state,
  output logic                                        o_frozen,
  output logic                                        o_alloc_match,
  output logic                                        o_store_match,
  output logic [OPTN_VB_LOOKUP_PORTS-1:0]             o_lookup_match,
  output logic [TAG_W-1:0]                            o_tag,
  output logic [LINE_W-1:0]                           o_data
);

  pcyn_vb_state_t    state_q, state_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [LINE_W-1:0] data_q, data_d;
  logic              frozen;
  logic              open_valid;
  logic              store_match;

  // A head entry is already on the CCU bus, so its data must stay put until grant.
  assign frozen     = (state_q == PCYN_VB_WB) || (i_head && (state_q == PCYN_VB_VALID));
  assign open_valid = (state_q == PCYN_VB_VALID) && !frozen;

`ifdef PCYN_VB_STORE_MERGE_EN
  assign store_match = i_store_valid && open_valid && (tag_q == i_store_tag);
`else
  logic unused_store;
  assign unused_store = ^{i_store_valid, i_store_tag, i_store_offset, i_store_byte_sel, i_store_data};
  assign store_match  = 1'b0;
`endif

  always_comb begin
    for (int p = 0; p < OPTN_VB_LOOKUP_PORTS; p++) begin
      o_lookup_match[p] = i_lookup_valid[p] && (state_q != PCYN_VB_INVALID) && (tag_q == i_lookup_tag[p]);
    end
  end

  assign o_alloc_match = i_victim_valid && open_valid && (tag_q == i_victim_tag);
  assign o_store_match = store_match;
  assign o_state       = state_q;
  assign o_frozen      = frozen;
  assign o_tag         = tag_q;
  assign o_data        = data_q;

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (i_head && i_grant && (state_q != PCYN_VB_INVALID)) begin
      state_d = PCYN_VB_INVALID;
    end else if (i_head && (state_q == PCYN_VB_VALID)) begin
      state_d = PCYN_VB_WB;
    end
    if (i_tail_we) begin
      state_d = PCYN_VB_VALID;
      tag_d   = i_victim_tag;
    end
    if (i_tail_we || o_alloc_match) data_d = i_victim_data;
`ifdef PCYN_VB_STORE_MERGE_EN
    // Applied after the victim write so a same-cycle store wins over the re-evicted bytes.
    if (store_match) begin
      data_d = LINE_W'(pcyn_vb_merge(pcyn_line_t'(data_d), OPTN_DC_LINE_SIZE, 32'(i_store_offset),
                                     pcyn_bsel_t'(i_store_byte_sel), pcyn_word_t'(i_store_data)));
    end
`endif
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= PCYN_VB_INVALID;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/procyon_vb.sv
// Victim buffer: FIFO of evicted dirty lines written back through the CCU, with parallel load lookups.
// Define PCYN_VB_STORE_MERGE_EN to let stores merge into queued, not-yet-presented lines.
module procyon_vb
  import procyon_vb_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH      = 32,
  parameter int OPTN_ADDR_WIDTH      = 32,
  parameter int OPTN_VB_DEPTH        = 4,
  parameter int OPTN_VB_LOOKUP_PORTS = 2,
  parameter int OPTN_DC_LINE_SIZE    = 32,
  localparam int DATA_SIZE = OPTN_DATA_WIDTH / 8,
  localparam int LINE_W    = OPTN_DC_LINE_SIZE * 8
) (
  input  logic                                                 clk,
  input  logic                                                 n_rst,
  output logic                                                 o_vb_full,
  output logic                                                 o_vb_empty,
  input  logic [OPTN_VB_LOOKUP_PORTS-1:0]                      i_vb_lookup_valid,
  input  logic [OPTN_VB_LOOKUP_PORTS-1:0][OPTN_ADDR_WIDTH-1:0] i_vb_lookup_addr,
  input  logic [OPTN_VB_LOOKUP_PORTS-1:0][DATA_SIZE-1:0]       i_vb_lookup_byte_sel,
  output logic [OPTN_VB_LOOKUP_PORTS-1:0]                      o_vb_lookup_hit,
  output logic [OPTN_VB_LOOKUP_PORTS-1:0][OPTN_DATA_WIDTH-1:0] o_vb_lookup_data,
  input  logic                                                 i_vb_store_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0]                           i_vb_store_addr,
  input  logic [DATA_SIZE-1:0]                                 i_vb_store_byte_sel,
  input  logic [OPTN_DATA_WIDTH-1:0]                           i_vb_store_data,
  output logic                                                 o_vb_store_hit,
  input  logic                                                 i_vb_victim_valid,
  input  logic [OPTN_ADDR_WIDTH-1:0]                           i_vb_victim_addr,
  input  logic [LINE_W-1:0]                                    i_vb_victim_data,
  input  logic                                                 i_ccu_grant,
  output logic                                                 o_ccu_en,
  output logic                                                 o_ccu_we,
  output pcyn_ccu_len_t                                        o_ccu_len,
  output logic [OPTN_ADDR_WIDTH-1:0]                           o_ccu_addr,
  output logic [LINE_W-1:0]                                    o_ccu_data
);

  localparam int OFF_W = $clog2(OPTN_DC_LINE_SIZE);
  localparam int TAG_W = OPTN_ADDR_WIDTH - OFF_W;
  localparam int IDX_W = $clog2(OPTN_VB_DEPTH);
  localparam int P     = OPTN_VB_LOOKUP_PORTS;

  logic [IDX_W:0]     head_q, head_d, tail_q, tail_d;
  logic               full_q, full_d, empty_q, empty_d;
  logic [P-1:0]       lookup_hit_q, lookup_hit_d;
  logic [P-1:0][OPTN_DATA_WIDTH-1:0] lookup_data_q, lookup_data_d;
  logic               store_hit_q, store_hit_d;

  pcyn_vb_state_t     ent_state [OPTN_VB_DEPTH];
  logic [TAG_W-1:0]   ent_tag [OPTN_VB_DEPTH];
  logic [LINE_W-1:0]  ent_data [OPTN_VB_DEPTH];
  logic [P-1:0]       ent_lookup_match [OPTN_VB_DEPTH];
  logic [OPTN_VB_DEPTH-1:0] ent_frozen, ent_alloc_match, ent_store_match, ent_head, ent_tail_we;

  logic [IDX_W-1:0]   head_idx;
  logic               ccu_en, grant_fire, tail_we;
  logic               store_valid;
  logic [P-1:0][TAG_W-1:0] lookup_tag;
  logic               unused_victim_off;

`ifdef PCYN_VB_STORE_MERGE_EN
  assign store_valid = i_vb_store_valid;
`else
  logic unused_store_valid;
  assign unused_store_valid = i_vb_store_valid;
  assign store_valid        = 1'b0;
`endif

  assign unused_victim_off = ^i_vb_victim_addr[OFF_W-1:0];

  assign head_idx   = head_q[IDX_W-1:0];
  assign ccu_en     = (ent_state[head_idx] != PCYN_VB_INVALID);
  assign grant_fire = i_ccu_grant && ccu_en;
  // Full is registered, so a same-cycle grant cannot make room for this victim.
  assign tail_we    = i_vb_victim_valid && !(|ent_alloc_match) && !full_q;

  always_comb begin
    for (int e = 0; e < OPTN_VB_DEPTH; e++) begin
      ent_head[e]    = (head_idx == IDX_W'(e));
      ent_tail_we[e] = tail_we && (tail_q[IDX_W-1:0] == IDX_W'(e));
    end
    for (int p = 0; p < P; p++) lookup_tag[p] = i_vb_lookup_addr[p][OPTN_ADDR_WIDTH-1:OFF_W];
  end

  for (genvar g = 0; g < OPTN_VB_DEPTH; g++) begin : g_entry
    procyon_vb_entry #(
      .OPTN_DATA_WIDTH      (OPTN_DATA_WIDTH),
      .OPTN_ADDR_WIDTH      (OPTN_ADDR_WIDTH),
      .OPTN_VB_LOOKUP_PORTS (OPTN_VB_LOOKUP_PORTS),
      .OPTN_DC_LINE_SIZE    (OPTN_DC_LINE_SIZE)
    ) u_entry (
      .clk              (clk),
      .n_rst            (n_rst),
      .i_head           (ent_head[g]),
      .i_grant          (grant_fire),
      .i_tail_we        (ent_tail_we[g]),
      .i_victim_valid   (i_vb_victim_valid),
      .i_victim_tag     (i_vb_victim_addr[OPTN_ADDR_WIDTH-1:OFF_W]),
      .i_victim_data    (i_vb_victim_data),
      .i_lookup_valid   (i_vb_lookup_valid),
      .i_lookup_tag     (lookup_tag),
      .i_store_valid    (store_valid),
      .i_store_tag      (i_vb_store_addr[OPTN_ADDR_WIDTH-1:OFF_W]),
      .i_store_offset   (i_vb_store_addr[OFF_W-1:0]),
      .i_store_byte_sel (i_vb_store_byte_sel),
      .i_store_data     (i_vb_store_data),
      .o_state          (ent_state[g]),
      .o_frozen         (ent_frozen[g]),
      .o_alloc_match    (ent_alloc_match[g]),
      .o_store_match    (ent_store_match[g]),
      .o_lookup_match   (ent_lookup_match[g]),
      .o_tag            (ent_tag[g]),
      .o_data           (ent_data[g])
    );
  end

  // An open (non-frozen) copy of a line is newer than a frozen one being written back.
  always_comb begin
    logic             nf_hit, fz_hit;
    logic [IDX_W-1:0] nf_idx, fz_idx, sel_idx;
    lookup_hit_d  = '0;
    lookup_data_d = '0;
    for (int p = 0; p < P; p++) begin
      nf_hit = 1'b0;
      fz_hit = 1'b0;
      nf_idx = '0;
      fz_idx = '0;
      for (int e = 0; e < OPTN_VB_DEPTH; e++) begin
        if (ent_lookup_match[e][p]) begin
          if (ent_frozen[e]) begin
            fz_hit = 1'b1;
            fz_idx = IDX_W'(e);
          end else begin
            nf_hit = 1'b1;
            nf_idx = IDX_W'(e);
          end
        end
      end
      sel_idx         = nf_hit ? nf_idx : fz_idx;
      lookup_hit_d[p] = nf_hit || fz_hit;
      if (nf_hit || fz_hit) begin
        lookup_data_d[p] = OPTN_DATA_WIDTH'(pcyn_vb_extract(pcyn_line_t'(ent_data[sel_idx]), OPTN_DC_LINE_SIZE,
                                                            32'(i_vb_lookup_addr[p][OFF_W-1:0]),
                                                            pcyn_bsel_t'(i_vb_lookup_byte_sel[p])));
      end
    end
  end

  always_comb begin
    store_hit_d = |ent_store_match;
    head_d      = head_q + (IDX_W+1)'(grant_fire);
    tail_d      = tail_q + (IDX_W+1)'(tail_we);
    empty_d     = (head_d == tail_d);
    full_d      = (head_d[IDX_W-1:0] == tail_d[IDX_W-1:0]) && (head_d[IDX_W] != tail_d[IDX_W]);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      lookup_hit_q  <= '0;
      lookup_data_q <= '0;
      store_hit_q   <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      full_q        <= full_d;
      empty_q       <= empty_d;
      lookup_hit_q  <= lookup_hit_d;
      lookup_data_q <= lookup_data_d;
      store_hit_q   <= store_hit_d;
    end
  end

  assign o_vb_full        = full_q;
  assign o_vb_empty       = empty_q;
  assign o_vb_lookup_hit  = lookup_hit_q;
  assign o_vb_lookup_data = lookup_data_q;
  assign o_vb_store_hit   = store_hit_q;
  assign o_ccu_en         = ccu_en;
  assign o_ccu_we         = 1'b1;
  assign o_ccu_len        = pcyn_ccu_len(OPTN_DC_LINE_SIZE);
  assign o_ccu_addr       = ccu_en ? {ent_tag[head_idx], {OFF_W{1'b0}}} : '0;
  assign o_ccu_data       = ccu_en ? ent_data[head_idx] : '0;

endmodule

// File: tb/tb_procyon_vb.sv
// Directed bench for procyon_vb (default parameters: 32-bit data/address, depth 4, 2 ports, 32-byte lines).
module tb_procyon_vb;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              vb_full, vb_empty;
  logic [1:0]        lk_valid;
  logic [1:0][31:0]  lk_addr;
  logic [1:0][3:0]   lk_sel;
  logic [1:0]        lk_hit;
  logic [1:0][31:0]  lk_data;
  logic              st_valid;
  logic [31:0]       st_addr;
  logic [3:0]        st_sel;
  logic [31:0]       st_data;
  logic              st_hit;
  logic              vic_valid;
  logic [31:0]       vic_addr;
  logic [255:0]      vic_data;
  logic              grant;
  logic              ccu_en, ccu_we;
  logic [2:0]        ccu_len;
  logic [31:0]       ccu_addr;
  logic [255:0]      ccu_data;

  int errors = 0;
  int checks = 0;
  logic [255:0] g_exp;
  logic         merge_on;

  procyon_vb dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .o_vb_full            (vb_full),
    .o_vb_empty           (vb_empty),
    .i_vb_lookup_valid    (lk_valid),
    .i_vb_lookup_addr     (lk_addr),
    .i_vb_lookup_byte_sel (lk_sel),
    .o_vb_lookup_hit      (lk_hit),
    .o_vb_lookup_data     (lk_data),
    .i_vb_store_valid     (st_valid),
    .i_vb_store_addr      (st_addr),
    .i_vb_store_byte_sel  (st_sel),
    .i_vb_store_data      (st_data),
    .o_vb_store_hit       (st_hit),
    .i_vb_victim_valid    (vic_valid),
    .i_vb_victim_addr     (vic_addr),
    .i_vb_victim_data     (vic_data),
    .i_ccu_grant          (grant),
    .o_ccu_en             (ccu_en),
    .o_ccu_we             (ccu_we),
    .o_ccu_len            (ccu_len),
    .o_ccu_addr           (ccu_addr),
    .o_ccu_data           (ccu_data)
  );

  always #5 clk = ~clk;

  // Line whose byte i holds seed+i.
  function automatic logic [255:0] mk(input logic [7:0] seed);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[i*8 +: 8] = seed + 8'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic victim(input logic [31:0] addr, input logic [7:0] seed);
    vic_valid = 1'b1;
    vic_addr  = addr;
    vic_data  = mk(seed);
    step();
    vic_valid = 1'b0;
  endtask

  initial begin
`ifdef PCYN_VB_STORE_MERGE_EN
    merge_on = 1'b1;
`else
    merge_on = 1'b0;
`endif
    n_rst = 1'b0; lk_valid = '0; lk_addr = '0; lk_sel = '0;
    st_valid = 1'b0; st_addr = '0; st_sel = '0; st_data = '0;
    vic_valid = 1'b0; vic_addr = '0; vic_data = '0; grant = 1'b0;
    #12;
    check("rst_empty", 256'(vb_empty), 256'(1));
    check("rst_full", 256'(vb_full), 256'(0));
    check("rst_ccu_en", 256'(ccu_en), 256'(0));
    check("rst_ccu_we", 256'(ccu_we), 256'(1));
    check("rst_ccu_len", 256'(ccu_len), 256'(3));
    check("rst_ccu_addr", 256'(ccu_addr), 256'(0));
    check("rst_lk_hit", 256'(lk_hit), 256'(0));
    check("rst_st_hit", 256'(st_hit), 256'(0));
    @(posedge clk); #1; n_rst = 1'b1;

    // Single allocate, then two-port lookup: hit on port0, miss on port1
    victim(32'h1000, 8'hA0);
    check("alloc_ccu_en", 256'(ccu_en), 256'(1));
    check("alloc_ccu_addr", 256'(ccu_addr), 256'(32'h1000));
    lk_valid = 2'b11; lk_addr[0] = 32'h1004; lk_addr[1] = 32'h2004; lk_sel[0] = 4'hF; lk_sel[1] = 4'hF;
    step();
    lk_valid = 2'b00;
    check("lk1_hit", 256'(lk_hit), 256'(2'b01));
    check("lk1_data0", 256'(lk_data[0]), 256'(32'hA7A6A5A4));
    check("lk1_data1", 256'(lk_data[1]), 256'(0));
    check("lk1_ccu_data", ccu_data, mk(8'hA0));

    // Fill to four entries, drop a fifth victim that arrives together with a grant
    victim(32'h1020, 8'hB0);
    victim(32'h1040, 8'hC0);
    check("fill3_full", 256'(vb_full), 256'(0));
    victim(32'h1060, 8'hD0);
    check("fill4_full", 256'(vb_full), 256'(1));
    grant = 1'b1;
    victim(32'h1080, 8'hE0);
    check("drop_full", 256'(vb_full), 256'(0));
    check("drain1_addr", 256'(ccu_addr), 256'(32'h1020));
    check("drain1_data", ccu_data, mk(8'hB0));
    step();
    check("drain2_addr", 256'(ccu_addr), 256'(32'h1040));
    step();
    check("drain3_addr", 256'(ccu_addr), 256'(32'h1060));
    check("drain3_data", ccu_data, mk(8'hD0));
    step();
    check("drain4_empty", 256'(vb_empty), 256'(1));
    check("drain4_ccu_en", 256'(ccu_en), 256'(0));
    step();
    check("idle_grant_empty", 256'(vb_empty), 256'(1));
    grant = 1'b0;

    // Store merge into a non-head entry; the head entry is frozen
    victim(32'h5000, 8'h50);
    victim(32'h3000, 8'h30);
    st_valid = 1'b1; st_addr = 32'h3008; st_sel = 4'h3; st_data = 32'h0000BEEF;
    step();
    st_valid = 1'b0;
    check("merge_st_hit", 256'(st_hit), 256'(merge_on));
    lk_valid = 2'b11; lk_addr[0] = 32'h3008; lk_sel[0] = 4'h3; lk_addr[1] = 32'h5000; lk_sel[1] = 4'hF;
    step();
    lk_valid = 2'b00;
    check("merge_lk_hit", 256'(lk_hit), 256'(2'b11));
    check("merge_lk_data0", 256'(lk_data[0]), merge_on ? 256'(32'h0000BEEF) : 256'(32'h00003938));
    check("merge_lk_data1", 256'(lk_data[1]), 256'(32'h53525150));
    st_valid = 1'b1; st_addr = 32'h5000; st_sel = 4'hF; st_data = 32'hDEADBEEF;
    step();
    st_valid = 1'b0;
    check("wb_st_hit", 256'(st_hit), 256'(0));
    check("wb_ccu_data", ccu_data, mk(8'h50));
    grant = 1'b1;
    step();
    grant = 1'b0;
    g_exp = mk(8'h30);
    if (merge_on) g_exp[64 +: 16] = 16'hBEEF;
    check("merged_ccu_addr", 256'(ccu_addr), 256'(32'h3000));
    check("merged_ccu_data", ccu_data, g_exp);
    st_valid = 1'b1; st_addr = 32'h3010; st_sel = 4'hF; st_data = 32'h12345678;
    step();
    st_valid = 1'b0;
    check("head_st_hit", 256'(st_hit), 256'(0));
    check("head_ccu_data", ccu_data, g_exp);
    grant = 1'b1;
    step();
    grant = 1'b0;
    check("merge_drain_empty", 256'(vb_empty), 256'(1));

    // Re-evict coalesces into an open entry, but allocates anew once the line is in writeback
    victim(32'h6000, 8'h60);
    victim(32'h4000, 8'h40);
    victim(32'h4000, 8'h70);
    lk_valid = 2'b01; lk_addr[0] = 32'h4004; lk_sel[0] = 4'hF;
    step();
    lk_valid = 2'b00;
    check("coal_lk_data", 256'(lk_data[0]), 256'(32'h77767574));
    grant = 1'b1;
    step();
    grant = 1'b0;
    step();
    check("coal_ccu_addr", 256'(ccu_addr), 256'(32'h4000));
    check("coal_ccu_data", ccu_data, mk(8'h70));
    victim(32'h4000, 8'h80);
    lk_valid = 2'b01;
    step();
    lk_valid = 2'b00;
    check("rewb_lk_data", 256'(lk_data[0]), 256'(32'h87868584));
    check("rewb_ccu_data", ccu_data, mk(8'h70));
    grant = 1'b1;
    step();
    check("rewb_next_addr", 256'(ccu_addr), 256'(32'h4000));
    check("rewb_next_data", ccu_data, mk(8'h80));
    step();
    grant = 1'b0;
    check("rewb_empty", 256'(vb_empty), 256'(1));

    // Asynchronous reset with three entries queued
    victim(32'h7000, 8'h11);
    victim(32'h7020, 8'h22);
    victim(32'h7040, 8'h33);
    lk_valid = 2'b01; lk_addr[0] = 32'h7020; lk_sel[0] = 4'hF;
    step();
    check("pre_rst_hit", 256'(lk_hit), 256'(2'b01));
    check("pre_rst_data", 256'(lk_data[0]), 256'(32'h25242322));
    #2; n_rst = 1'b0; #1;
    check("mid_rst_empty", 256'(vb_empty), 256'(1));
    check("mid_rst_ccu_en", 256'(ccu_en), 256'(0));
    check("mid_rst_ccu_addr", 256'(ccu_addr), 256'(0));
    check("mid_rst_ccu_data", ccu_data, 256'(0));
    check("mid_rst_lk_hit", 256'(lk_hit), 256'(0));
    check("mid_rst_lk_data", 256'(lk_data[0]), 256'(0));
    lk_valid = 2'b00;
    step();
    n_rst = 1'b1;
    step();
    check("post_rst_empty", 256'(vb_empty), 256'(1));
    check("post_rst_ccu_en", 256'(ccu_en), 256'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
